// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - registered program counter with condition evaluation, halt state and circular return-address stack
module pc_sequencer #(
  parameter int              PC_W       = 16,
  parameter int              IMM_W      = 9,
  parameter int              INST_BYTES = 2,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_valid,
  input  logic             br_mode,
  input  logic [2:0]       cond,
  input  logic [2:0]       flags,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  rs_val,
  input  logic             call,
  input  logic             ret,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus,
  output logic             taken,
  output logic             halted,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr, ras_ptr_nxt, ras_wa;
  logic [CNT_W-1:0] ras_cnt, ras_cnt_nxt;
  logic             ras_we, ovf_nxt, unf_nxt;
  logic             cond_met, br_taken, run_upd, push;
  logic             ras_empty, ras_full;
  logic [PC_W-1:0]  br_target, imm_sext;

  wire flag_v = flags[2];
  wire flag_n = flags[1];
  wire flag_z = flags[0];

  always_comb begin
    cond_met = 1'b0;
    case (cond)
      3'b000:  cond_met = ~flag_z;
      3'b001:  cond_met = flag_z;
      3'b010:  cond_met = ~flag_z & ~flag_n;
      3'b011:  cond_met = flag_n;
      3'b100:  cond_met = flag_z | ~flag_n;
      3'b101:  cond_met = flag_z | flag_n;
      3'b110:  cond_met = flag_v;
      default: cond_met = 1'b1;
    endcase
  end

  assign pc_plus   = pc + PC_W'(INST_BYTES);
  assign imm_sext  = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign br_target = br_mode ? rs_val : pc_plus + (imm_sext << 1);
  assign br_taken  = br_valid & cond_met;
  assign run_upd   = (state == RUN) & ~stall & ~halt;
  assign taken     = run_upd & (ret | br_taken);
  assign push      = run_upd & call & br_taken;
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign halted    = (state == HALTED);

  always_comb begin
    state_nxt = state;
    if (state == RUN && halt && !stall)
      state_nxt = HALTED;
  end

  // ret beats branch; a simultaneous call+ret swaps the top entry in place
  always_comb begin
    pc_nxt      = pc;
    ras_ptr_nxt = ras_ptr;
    ras_cnt_nxt = ras_cnt;
    ras_we      = 1'b0;
    ras_wa      = ras_ptr;
    ovf_nxt     = 1'b0;
    unf_nxt     = 1'b0;
    if (run_upd) begin
      if (ret)
        pc_nxt = ras_empty ? rs_val : ras_mem[ras_ptr];
      else if (br_taken)
        pc_nxt = br_target;
      else
        pc_nxt = pc_plus;

      if (push && ret) begin
        ras_we = 1'b1;
        if (ras_empty) begin
          ras_wa      = ras_ptr + 1'b1;
          ras_ptr_nxt = ras_ptr + 1'b1;
          ras_cnt_nxt = CNT_W'(1);
          unf_nxt     = 1'b1;
        end
      end else if (push) begin
        ras_we      = 1'b1;
        ras_wa      = ras_ptr + 1'b1;
        ras_ptr_nxt = ras_ptr + 1'b1;
        if (ras_full)
          ovf_nxt = 1'b1;
        else
          ras_cnt_nxt = ras_cnt + 1'b1;
      end else if (ret) begin
        if (ras_empty) begin
          unf_nxt = 1'b1;
        end else begin
          ras_ptr_nxt = ras_ptr - 1'b1;
          ras_cnt_nxt = ras_cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      pc            <= RESET_PC;
      ras_ptr       <= '0;
      ras_cnt       <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      ras_ptr       <= ras_ptr_nxt;
      ras_cnt       <= ras_cnt_nxt;
      ras_overflow  <= ovf_nxt;
      ras_underflow <= unf_nxt;
    end
  end

  // Entries are only ever read when the count says they are valid, so no reset
  always_ff @(posedge clk) begin
    if (ras_we)
      ras_mem[ras_wa] <= pc_plus;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, stall, halt, br_valid, br_mode, call, ret;
  logic [2:0]  cond, flags;
  logic [8:0]  imm;
  logic [15:0] rs_val;
  logic [15:0] pc, pc_plus;
  logic        taken, halted, ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt),
    .br_valid(br_valid), .br_mode(br_mode), .cond(cond), .flags(flags),
    .imm(imm), .rs_val(rs_val), .call(call), .ret(ret),
    .pc(pc), .pc_plus(pc_plus), .taken(taken), .halted(halted),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  task automatic idle_inputs();
    stall = 0; halt = 0; br_valid = 0; br_mode = 0; cond = 0; flags = 0;
    imm = 0; rs_val = 0; call = 0; ret = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [15:0] v);
    idle_inputs();
    br_valid = 1; br_mode = 1; cond = 3'b111; rs_val = v;
    step();
    idle_inputs();
  endtask

  task automatic do_call(input logic [15:0] target);
    idle_inputs();
    br_valid = 1; br_mode = 1; cond = 3'b111; rs_val = target; call = 1;
    step();
    idle_inputs();
  endtask

  function automatic logic exp_cond(input logic [2:0] c, input logic [2:0] f);
    logic v, n, z;
    {v, n, z} = f;
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic test_reset();
    logic [15:0] exp_pc;
    idle_inputs();
    rst_n = 0;
    #12 rst_n = 1;
    step(); step();
    #2 rst_n = 0;
    #1;
    checks++;
    if (pc !== 16'h0000) begin errors++; $display("FAIL reset_async_pc: got %h expected 0000", pc); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    @(negedge clk);
    rst_n = 1;
    exp_pc = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 16'd2;
      checks++;
      if (pc !== exp_pc) begin errors++; $display("FAIL reset_idle_%0d: got %h expected %h", i, pc, exp_pc); end
    end
  endtask

  task automatic test_conditions();
    logic met;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        set_pc(16'h0010);
        br_valid = 1; br_mode = 0; imm = 9'h1FC;
        cond = 3'(c); flags = 3'(f);
        met = exp_cond(3'(c), 3'(f));
        #1;
        checks++;
        if (taken !== met) begin errors++; $display("FAIL cond_taken c=%0d f=%0d: got %b expected %b", c, f, taken, met); end
        step();
        checks++;
        if (pc !== (met ? 16'h000A : 16'h0012)) begin
          errors++; $display("FAIL cond_pc c=%0d f=%0d: got %h expected %h", c, f, pc, met ? 16'h000A : 16'h0012);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_br();
    set_pc(16'hFFFE);
    step();
    checks++;
    if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_seq: got %h expected 0000", pc); end
    set_pc(16'hFFFC);
    br_valid = 1; br_mode = 0; cond = 3'b111; imm = 9'd3;
    step();
    checks++;
    if (pc !== 16'h0004) begin errors++; $display("FAIL wrap_branch: got %h expected 0004", pc); end
    idle_inputs();
    br_valid = 1; br_mode = 1; cond = 3'b111; rs_val = 16'h1234;
    step();
    checks++;
    if (pc !== 16'h1234) begin errors++; $display("FAIL br_reg: got %h expected 1234", pc); end
    idle_inputs();
  endtask

  task automatic test_stall_halt();
    set_pc(16'h0040);
    stall = 1; br_valid = 1; br_mode = 1; cond = 3'b111; rs_val = 16'h0800; call = 1;
    #1;
    checks++;
    if (taken !== 1'b0) begin errors++; $display("FAIL stall_taken: got %b expected 0", taken); end
    step();
    checks++;
    if (pc !== 16'h0040) begin errors++; $display("FAIL stall_pc: got %h expected 0040", pc); end
    idle_inputs();
    ret = 1; rs_val = 16'h5555;
    step();
    checks++;
    if (pc !== 16'h5555) begin errors++; $display("FAIL stall_no_push_pc: got %h expected 5555", pc); end
    checks++;
    if (ras_underflow !== 1'b1) begin errors++; $display("FAIL stall_no_push_unf: got %b expected 1", ras_underflow); end
    idle_inputs();
    halt = 1; br_valid = 1; cond = 3'b111; br_mode = 1; rs_val = 16'h0AAA;
    #1;
    checks++;
    if (taken !== 1'b0) begin errors++; $display("FAIL halt_taken: got %b expected 0", taken); end
    step();
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_state: got %b expected 1", halted); end
    checks++;
    if (pc !== 16'h5555) begin errors++; $display("FAIL halt_pc: got %h expected 5555", pc); end
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      br_valid = 1; br_mode = 1; cond = 3'b111; rs_val = 16'(i * 16); ret = i[0]; call = i[1];
      step();
      checks++;
      if (pc !== 16'h5555 || halted !== 1'b1) begin
        errors++; $display("FAIL halt_frozen_%0d: got pc=%h halted=%b expected pc=5555 halted=1", i, pc, halted);
      end
    end
    idle_inputs();
    rst_n = 0;
    #1;
    checks++;
    if (pc !== 16'h0000 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset: got pc=%h halted=%b expected pc=0000 halted=0", pc, halted);
    end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  task automatic test_ras();
    logic [15:0] exp_ret [4];
    exp_ret = '{16'h0502, 16'h0402, 16'h0302, 16'h0202};
    set_pc(16'h0100);
    for (int i = 0; i < 5; i++) begin
      do_call(16'((i + 2) * 256));
      checks++;
      if (pc !== 16'((i + 2) * 256) || ras_overflow !== (i == 4)) begin
        errors++; $display("FAIL ras_call_%0d: got pc=%h ovf=%b expected pc=%h ovf=%b", i, pc, ras_overflow, 16'((i + 2) * 256), i == 4);
      end
    end
    step();
    checks++;
    if (ras_overflow !== 1'b0) begin errors++; $display("FAIL ras_ovf_pulse: got %b expected 0", ras_overflow); end
    for (int i = 0; i < 4; i++) begin
      ret = 1; rs_val = 16'hBEEF;
      #1;
      checks++;
      if (taken !== 1'b1) begin errors++; $display("FAIL ras_ret_taken_%0d: got %b expected 1", i, taken); end
      step();
      checks++;
      if (pc !== exp_ret[i] || ras_underflow !== 1'b0) begin
        errors++; $display("FAIL ras_ret_%0d: got pc=%h unf=%b expected pc=%h unf=0", i, pc, ras_underflow, exp_ret[i]);
      end
    end
    step();
    checks++;
    if (pc !== 16'hBEEF || ras_underflow !== 1'b1) begin
      errors++; $display("FAIL ras_underflow: got pc=%h unf=%b expected pc=BEEF unf=1", pc, ras_underflow);
    end
    idle_inputs();
    step();
    checks++;
    if (ras_underflow !== 1'b0) begin errors++; $display("FAIL ras_unf_pulse: got %b expected 0", ras_underflow); end
  endtask

  task automatic test_simultaneous();
    set_pc(16'h00FE);
    do_call(16'h0020);
    br_valid = 1; br_mode = 1; cond = 3'b111; call = 1; ret = 1; rs_val = 16'h7777;
    step();
    checks++;
    if (pc !== 16'h0100 || ras_underflow !== 1'b0 || ras_overflow !== 1'b0) begin
      errors++; $display("FAIL sim_swap: got pc=%h unf=%b ovf=%b expected pc=0100 unf=0 ovf=0", pc, ras_underflow, ras_overflow);
    end
    idle_inputs();
    ret = 1; rs_val = 16'h9999;
    step();
    checks++;
    if (pc !== 16'h0022) begin errors++; $display("FAIL sim_new_top: got %h expected 0022", pc); end
    step();
    checks++;
    if (pc !== 16'h9999 || ras_underflow !== 1'b1) begin
      errors++; $display("FAIL sim_count_kept: got pc=%h unf=%b expected pc=9999 unf=1", pc, ras_underflow);
    end
    idle_inputs();
    br_valid = 1; br_mode = 1; cond = 3'b111; call = 1; ret = 1; rs_val = 16'h3333;
    step();
    checks++;
    if (pc !== 16'h3333 || ras_underflow !== 1'b1) begin
      errors++; $display("FAIL sim_empty: got pc=%h unf=%b expected pc=3333 unf=1", pc, ras_underflow);
    end
    idle_inputs();
    ret = 1; rs_val = 16'h4444;
    step();
    checks++;
    if (pc !== 16'h999B || ras_underflow !== 1'b0) begin
      errors++; $display("FAIL sim_empty_push: got pc=%h unf=%b expected pc=999B unf=0", pc, ras_underflow);
    end
    step();
    checks++;
    if (pc !== 16'h4444 || ras_underflow !== 1'b1) begin
      errors++; $display("FAIL sim_empty_count1: got pc=%h unf=%b expected pc=4444 unf=1", pc, ras_underflow);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_conditions();
    test_wrap_br();
    test_stall_halt();
    test_ras();
    test_simultaneous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
